// File: rtl/i2c_master_read_byte.sv
// I2C byte reader: sequences DATA_WIDTH bit reads through the bit-read stage,
// assembles them MSB-first, then drives ACK/NACK with its own 8-phase SCL.
module i2c_master_read_byte #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic                  ack_n,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  finish,
  output logic                  error,
  output logic                  bit_go,
  input  logic                  bit_data,
  input  logic                  bit_finish,
  input  logic                  bit_error,
  input  logic                  bit_scl,
  output logic                  scl,
  output logic                  sda_out,
  output logic                  sda_oe
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, READ, GAP, ACK, DONE} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n, dout_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [2:0]            phase, phase_n;
  logic                  ack_q, ack_q_n, err_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      phase    <= '0;
      ack_q    <= 1'b1;
      error    <= 1'b0;
      data_out <= '0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      cnt      <= cnt_n;
      phase    <= phase_n;
      ack_q    <= ack_q_n;
      error    <= err_n;
      data_out <= dout_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    phase_n = phase;
    ack_q_n = ack_q;
    err_n   = error;
    dout_n  = data_out;
    case (state)
      IDLE: if (go) begin
        ack_q_n = ack_n;
        shreg_n = '0;
        cnt_n   = '0;
        phase_n = '0;
        err_n   = 1'b0;
        state_n = READ;
      end
      // Abort on dropped go takes priority over a coincident bit_finish.
      READ: if (!go) state_n = IDLE;
      else if (bit_finish) begin
        if (bit_error) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else begin
          shreg_n = {shreg[DATA_WIDTH-2:0], bit_data};
          if (cnt == CW'(DATA_WIDTH-1)) state_n = ACK;
          else begin
            cnt_n   = cnt + CW'(1);
            state_n = GAP;
          end
        end
      end
      GAP: state_n = go ? READ : IDLE;
      ACK: if (!go) state_n = IDLE;
      else if (phase == 3'd7) begin
        phase_n = '0;
        dout_n  = shreg;
        state_n = DONE;
      end else phase_n = phase + 3'd1;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode registered state; only READ/GAP pass bit_scl through.
  assign bit_go  = (state == READ);
  assign finish  = (state == DONE);
  assign sda_oe  = (state == ACK);
  assign sda_out = (state == ACK) ? ack_q : 1'b1;
  assign scl     = (state == READ || state == GAP) ? bit_scl :
                   (state == ACK) ? phase[2] : 1'b1;
endmodule

// File: tb/tb_i2c_master_read_byte.sv
// Scoreboard bench for i2c_master_read_byte with a behavioural bit-read stage.
module tb_i2c_master_read_byte;
  logic       clock = 1'b0;
  logic       reset_n, go, ack_n;
  logic [7:0] data_out;
  logic       finish, error, bit_go, bit_data, bit_finish, bit_error, bit_scl;
  logic       scl, sda_out, sda_oe;

  always #5 clock = ~clock;

  i2c_master_read_byte #(.DATA_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .go(go), .ack_n(ack_n),
    .data_out(data_out), .finish(finish), .error(error), .bit_go(bit_go),
    .bit_data(bit_data), .bit_finish(bit_finish), .bit_error(bit_error),
    .bit_scl(bit_scl), .scl(scl), .sda_out(sda_out), .sda_oe(sda_oe)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic       ack_n;
    logic       has_ack;
    int         lat;
  } exp_t;

  exp_t sq[$];
  logic bq[$];
  logic eq[$];
  int   total = 0;
  int   pass  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Bit-read stage model: bit_finish 8 cycles after bit_go rises.
  logic [3:0] mcnt;
  assign bit_scl = mcnt[2];
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcnt <= '0; bit_finish <= 1'b0; bit_data <= 1'b0; bit_error <= 1'b0;
    end else if (!bit_go) begin
      mcnt <= '0; bit_finish <= 1'b0;
    end else begin
      mcnt <= mcnt + 4'd1;
      if (mcnt == 4'd7) begin
        bit_finish <= 1'b1;
        if (bq.size() > 0) begin
          bit_data  <= bq[0];
          bit_error <= eq[0];
          void'(bq.pop_front());
          void'(eq.pop_front());
        end else begin
          bit_data <= 1'b0; bit_error <= 1'b0;
        end
      end else bit_finish <= 1'b0;
    end
  end

  // Monitor: samples each cycle just after the active edge.
  int   lat, ackc, lowrun;
  logic in_xfer, scl_bad, gap_bad, ack_bad, prev_fin;
  initial begin
    in_xfer = 0; lat = 0; ackc = 0; lowrun = 0;
    scl_bad = 0; gap_bad = 0; ack_bad = 0; prev_fin = 0;
  end
  always @(posedge clock) begin
    #1;
    if (!reset_n || !go) begin
      in_xfer = 0; ackc = 0; lowrun = 0; ack_bad = 0; prev_fin = finish;
    end else begin
      if (in_xfer) lat++;
      else if (bit_go) begin
        in_xfer = 1; lat = 1; lowrun = 0; scl_bad = 0; gap_bad = 0; ack_bad = 0; ackc = 0;
      end
      if (bit_go && scl !== bit_scl) scl_bad = 1;
      if (in_xfer) begin
        if (!bit_go && !sda_oe && !finish) lowrun++;
        else if (bit_go && lowrun != 0) begin
          if (lowrun != 1) gap_bad = 1;
          lowrun = 0;
        end
      end
      if (sda_oe) begin
        ackc++;
        if (sq.size() == 0 || sda_out !== sq[0].ack_n || scl !== 1'(ackc > 4)) ack_bad = 1;
      end
      if (finish) begin
        if (sq.size() == 0) check("unexpected_finish", 1, 0);
        else begin
          exp_t e;
          e = sq.pop_front();
          check("data_out", data_out, e.data);
          check("error", error, e.err);
          check("ack_cycles", ackc, e.has_ack ? 8 : 0);
          check("ack_sda_scl", ack_bad, 0);
          check("latency", lat, e.lat);
          check("bit_gap", gap_bad, 0);
          check("scl_mux", scl_bad, 0);
          check("finish_single", prev_fin, 0);
        end
        in_xfer = 0; ackc = 0; lowrun = 0; ack_bad = 0;
      end
      prev_fin = finish;
    end
  end

  task automatic start(input logic [7:0] b, input int err_idx, input logic an,
                       input logic [7:0] exp_d, input int l, input bit push_exp);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (err_idx >= 0 && i > err_idx) break;
      bq.push_back(b[7-i]);
      eq.push_back(i == err_idx);
    end
    e.data = exp_d; e.err = (err_idx >= 0); e.ack_n = an;
    e.has_ack = (err_idx < 0); e.lat = l;
    if (push_exp) sq.push_back(e);
  endtask

  task automatic wait_fin(input string nm);
    int k;
    k = 0;
    do begin @(negedge clock); k++; end while (!finish && k < 300);
    check(nm, finish, 1);
  endtask

  initial begin
    int n;
    logic seen;
    reset_n = 0; go = 0; ack_n = 0;
    #3;
    check("rst_data_out", data_out, 8'h00);
    check("rst_outs", {finish, error, bit_go, scl, sda_out, sda_oe}, 6'b000110);
    repeat (2) @(negedge clock);
    reset_n = 1;
    @(negedge clock);

    // 1,0,1,0,0,1,0,1 with ACK
    ack_n = 0; start(8'hA5, -1, 1'b0, 8'hA5, 88, 1);
    go = 1; wait_fin("fin_a5"); go = 0;
    repeat (2) @(negedge clock);

    // bit error on third bit; data_out keeps A5
    start(8'hA0, 2, 1'b0, 8'hA5, 30, 1);
    go = 1; wait_fin("fin_err"); go = 0;
    repeat (2) @(negedge clock);

    // all ones with NACK
    ack_n = 1; start(8'hFF, -1, 1'b1, 8'hFF, 88, 1);
    go = 1; wait_fin("fin_ff"); go = 0;
    repeat (2) @(negedge clock);

    // back-to-back with go held
    ack_n = 0;
    start(8'h3C, -1, 1'b0, 8'h3C, 88, 1);
    start(8'hC3, -1, 1'b0, 8'hC3, 88, 1);
    go = 1; wait_fin("fin_3c");
    n = 0;
    do begin @(negedge clock); n++; end while (!bit_go && n < 10);
    check("idle_between", n, 2);
    wait_fin("fin_c3"); go = 0;
    repeat (2) @(negedge clock);

    // abort during bit 5
    start(8'hFF, -1, 1'b0, 8'h00, 0, 0);
    go = 1;
    n = 0;
    while (bq.size() > 4 && n < 200) begin @(negedge clock); n++; end
    check("abort_reach", n < 200, 1);
    repeat (3) @(negedge clock);
    go = 0;
    @(negedge clock);
    check("abort_outs", {finish, bit_go, scl, sda_out, sda_oe}, 5'b00110);
    seen = 0;
    repeat (5) begin @(negedge clock); if (finish) seen = 1; end
    check("abort_no_fin", seen, 0);
    check("abort_keep", {error, data_out}, {1'b0, 8'hC3});
    bq.delete(); eq.delete();

    start(8'h5A, -1, 1'b0, 8'h5A, 88, 1);
    go = 1; wait_fin("fin_5a"); go = 0;
    repeat (2) @(negedge clock);
    check("sb_drained", sq.size(), 0);

    // async reset in ACK phase 2
    start(8'h77, -1, 1'b0, 8'h77, 88, 1);
    go = 1;
    n = 0;
    while (!sda_oe && n < 200) begin @(negedge clock); n++; end
    check("ack_reach", sda_oe, 1);
    repeat (2) @(negedge clock);
    #2 reset_n = 0;
    #1;
    check("arst_data_out", data_out, 8'h00);
    check("arst_outs", {finish, error, bit_go, scl, sda_out, sda_oe}, 6'b000110);
    sq.delete(); bq.delete(); eq.delete();
    go = 0;
    @(negedge clock);
    reset_n = 1;
    repeat (3) @(negedge clock);
    check("post_rst_idle", {finish, bit_go, scl, sda_oe}, 4'b0010);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
